mvm_seq_ctrl_relu: RTL and testbench
====================================

// Module: mvm_seq_ctrl_relu
// PURPOSE
//  Sequencer for the saturating-MAC ReLU matrix-vector datapath (datapath_gen_p3_relu family).
//  Accepts an N-element input vector over a valid/ready stream and writes it into the datapath
//  vector memory. It then runs M/P row groups: clear, N MAC cycles, pipeline drain, then P
//  outputs streamed out via f_sel. Drives every datapath control input; the datapath is not
//  modified.
// PARAMETERS
//  M  8  matrix rows (outputs per vector); M % P == 0 required (elaboration $error otherwise)
//  N  8  matrix columns / vector length; N >= 2
//  T  8  data width, signed two's complement
//  P  1  parallel MAC lanes; G = M/P row groups
//  VECTOR_SIZE = $clog2(N), MATRIX_SIZE = $clog2(M*N/P) (localparams)
// PORTS
//  clk        in   1            clock, all state on posedge
//  reset      in   1            synchronous, active-high
//  s_valid    in   1            input element valid
//  s_ready    out  1            controller accepts element this cycle
//  s_data     in   T            input element (signed)
//  m_valid    out  1            output element valid
//  m_ready    in   1            downstream accepts output
//  m_data     out  T            output element = dp_y (combinational pass-through)
//  m_last     out  1            with m_valid: final output (row M-1) of current vector
//  busy       out  1            high whenever state != LOAD or load count != 0
//  dp_input_data out T          to datapath input_data = s_data
//  dp_wr_en_x out  1            vector memory write = s_valid & s_ready
//  dp_addr_x  out  VECTOR_SIZE  vector memory address
//  dp_addr_w  out  MATRIX_SIZE  weight ROM address
//  dp_clear_acc out 1           accumulator clear (one-cycle pulse)
//  dp_en_acc  out  1            accumulator enable
//  dp_f_sel   out  P-width      lane select for dp_y; width P matches datapath port
//  dp_y       in   T            datapath m_data_out_y (ReLU'd accumulator of lane f_sel)
// BEHAVIOUR
//  Datapath timing: vector memory and ROM read 1 cycle after address; product registers 1
//   cycle later. An address issued in cycle t therefore needs dp_en_acc high in cycle t+2.
//  States: LOAD -> CLEAR -> MAC -> DRAIN -> OUT -> (CLEAR if group<G-1, else LOAD).
//  LOAD: s_ready=1; each handshake writes s_data at dp_addr_x=ld_cnt; ld_cnt++.
//   The Nth handshake moves to CLEAR with group=0. Gaps in s_valid simply stall.
//  CLEAR: 1 cycle; dp_clear_acc=1, s_ready=0.
//  MAC: N cycles, j=0..N-1; dp_addr_x=j; dp_addr_w=group*N+j.
//   dp_en_acc is a 2-cycle delayed copy of the MAC-issue flag (shift register, not recomputed).
//  DRAIN: 2 cycles; dp_en_acc still high (from the delay line), no new addresses.
//  OUT: m_valid=1; dp_f_sel=out_cnt (0..P-1); m_data=dp_y.
//   out_cnt advances only on m_valid&m_ready; m_valid and m_data are held stable under
//   backpressure. en_acc=0, so the accumulators hold.
//   m_last=1 when group==G-1 and out_cnt==P-1.
//   After the P-th transfer: group<G-1 -> group++, CLEAR; else -> LOAD, ld_cnt=0.
//  Per-group latency: CLEAR to first m_valid = N+3 cycles.
//  Idle/default values: dp_addr_x and dp_addr_w drive 0 when not in use; dp_f_sel=0 outside OUT.
//  Reset: while reset is high, every output is forced to 0 combinationally, including s_ready,
//   m_valid, dp_wr_en_x, dp_en_acc and dp_clear_acc. At the clock edge, state=LOAD; all
//   counters and the en_acc delay line are cleared. This holds mid-operation, and a partial
//   vector is discarded. The first cycle after reset drops: s_ready=1, busy=0.
//  Counter wrap: ld_cnt, j and out_cnt each reset to 0 on their terminal transition and never
//   exceed N-1 / P-1 (correct for non-power-of-2 N).
//  No overlap of LOAD with compute: the next vector is not accepted until the last output
//   transfers.
// TESTING
//  1 Defaults. Reset, then stream x=1..8 with s_valid held high.
//    -> dp_wr_en_x for 8 cycles at addr 0..7; clear_acc pulse; addr_w 0..7; en_acc high for
//       exactly cycles CLEAR+3..CLEAR+10; m_valid at CLEAR+11; m_data matches the
//       golden ReLU(sat dot) for row 0.
//  2 Full vector. m_ready held 1 -> 8 groups of N+4 cycles each; m_last only on the 8th
//    output; s_ready returns to 1 the cycle after that transfer.
//  3 Backpressure. M=4, N=4, P=2. m_ready low for 5 cycles in OUT -> m_valid, dp_f_sel and
//    m_data held constant. Then f_sel 0 then 1; addr_w group 1 = 4..7.
//  4 Input gaps. s_valid toggling 1,0,1,0 -> ld_cnt advances only on handshakes; CLEAR only
//    after the 8th accepted element.
//  5 Reset mid-MAC. Assert reset at j=3 -> all outputs 0 that cycle; next cycle state LOAD,
//    s_ready=1, en_acc=0. A fresh vector then yields correct results (no stale accumulation).
//  6 Saturation/ReLU. Vector of all +127 against the default weights -> every m_data is in
//    [0,127]; no output is negative.

Source files
------------

// File: rtl/mvm_seq_ctrl_relu.sv
// Sequencer for the saturating-MAC ReLU matrix-vector datapath.
// Loads an N-element vector over a valid/ready stream into the datapath
// vector memory, then walks G = M/P row groups: clear, N MAC issues, a
// two-cycle pipeline drain and P output transfers selected through f_sel.
//
// Stream handshakes (both the s_* input and the m_* output side): an element
// transfers on a rising clock edge where valid and ready are both high.
// The producer keeps valid and data stable until that edge; ready may be
// driven without looking at valid. Here s_ready depends only on state, and
// m_valid/m_data/dp_f_sel are held unchanged while m_ready is low.
module mvm_seq_ctrl_relu #(
    parameter int M = 8,
    parameter int N = 8,
    parameter int T = 8,
    parameter int P = 1
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                s_valid,
    output logic                                s_ready,
    input  logic [T-1:0]                        s_data,
    output logic                                m_valid,
    input  logic                                m_ready,
    output logic [T-1:0]                        m_data,
    output logic                                m_last,
    output logic                                busy,
    output logic [T-1:0]                        dp_input_data,
    output logic                                dp_wr_en_x,
    output logic [$clog2(N)-1:0]                dp_addr_x,
    output logic [$clog2(M*N/P)-1:0]            dp_addr_w,
    output logic                                dp_clear_acc,
    output logic                                dp_en_acc,
    output logic [P-1:0]                        dp_f_sel,
    input  logic [T-1:0]                        dp_y,
    output logic [2:0]                          dbg_state_o
);

    localparam int VECTOR_SIZE = $clog2(N);
    localparam int MATRIX_SIZE = $clog2(M * N / P);
    localparam int G           = M / P;
    localparam int OW          = (P > 1) ? $clog2(P) : 1;
    localparam int GW          = (G > 1) ? $clog2(G) : 1;

    // Parameter sanity: the row groups must tile M exactly and the MAC loop
    // needs at least two columns.
    generate
        if (M % P != 0) begin : g_bad_mp
            $error("mvm_seq_ctrl_relu: M must be a multiple of P");
        end
        if (N < 2) begin : g_bad_n
            $error("mvm_seq_ctrl_relu: N must be at least 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_CLEAR = 3'd1,
        ST_MAC   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4
    } state_t;

    state_t                 state_q,   state_d;
    logic [VECTOR_SIZE-1:0] ld_cnt_q,  ld_cnt_d;
    logic [VECTOR_SIZE-1:0] j_q,       j_d;
    logic                   drain_q,   drain_d;
    logic [OW-1:0]          out_cnt_q, out_cnt_d;
    logic [GW-1:0]          group_q,   group_d;
    // en_acc delay line: bit 0 = issued last cycle, bit 1 = issued two ago.
    logic [1:0]             en_pipe_q, en_pipe_d;
    logic                   mac_issue;

    // State register, counters and the en_acc delay line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_LOAD;
            ld_cnt_q  <= '0;
            j_q       <= '0;
            drain_q   <= 1'b0;
            out_cnt_q <= '0;
            group_q   <= '0;
            en_pipe_q <= '0;
        end else begin
            state_q   <= state_d;
            ld_cnt_q  <= ld_cnt_d;
            j_q       <= j_d;
            drain_q   <= drain_d;
            out_cnt_q <= out_cnt_d;
            group_q   <= group_d;
            en_pipe_q <= en_pipe_d;
        end
    end

    // Next-state logic and all datapath/stream controls; reset blanks outputs.
    always_comb begin
        state_d       = state_q;
        ld_cnt_d      = ld_cnt_q;
        j_d           = j_q;
        drain_d       = drain_q;
        out_cnt_d     = out_cnt_q;
        group_d       = group_q;
        mac_issue     = 1'b0;

        s_ready       = 1'b0;
        dp_wr_en_x    = 1'b0;
        dp_addr_x     = '0;
        dp_addr_w     = '0;
        dp_clear_acc  = 1'b0;
        m_valid       = 1'b0;
        m_last        = 1'b0;
        dp_f_sel      = '0;

        unique case (state_q)
            ST_LOAD: begin
                s_ready    = 1'b1;
                dp_addr_x  = ld_cnt_q;
                dp_wr_en_x = s_valid;
                if (s_valid) begin
                    if (ld_cnt_q == VECTOR_SIZE'(N - 1)) begin
                        ld_cnt_d = '0;
                        group_d  = '0;
                        state_d  = ST_CLEAR;
                    end else begin
                        ld_cnt_d = ld_cnt_q + 1'b1;
                    end
                end
            end
            ST_CLEAR: begin
                dp_clear_acc = 1'b1;
                j_d          = '0;
                state_d      = ST_MAC;
            end
            ST_MAC: begin
                mac_issue = 1'b1;
                dp_addr_x = j_q;
                dp_addr_w = MATRIX_SIZE'(group_q) * MATRIX_SIZE'(N)
                          + MATRIX_SIZE'(j_q);
                if (j_q == VECTOR_SIZE'(N - 1)) begin
                    j_d     = '0;
                    drain_d = 1'b0;
                    state_d = ST_DRAIN;
                end else begin
                    j_d = j_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                // The last two issued products are still in flight.
                if (drain_q) begin
                    drain_d   = 1'b0;
                    out_cnt_d = '0;
                    state_d   = ST_OUT;
                end else begin
                    drain_d = 1'b1;
                end
            end
            ST_OUT: begin
                m_valid              = 1'b1;
                dp_f_sel[OW-1:0]     = out_cnt_q;
                m_last               = (group_q == GW'(G - 1))
                                    && (out_cnt_q == OW'(P - 1));
                if (m_ready) begin
                    if (out_cnt_q == OW'(P - 1)) begin
                        out_cnt_d = '0;
                        if (group_q == GW'(G - 1)) begin
                            group_d  = '0;
                            ld_cnt_d = '0;
                            state_d  = ST_LOAD;
                        end else begin
                            group_d = group_q + 1'b1;
                            state_d = ST_CLEAR;
                        end
                    end else begin
                        out_cnt_d = out_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        en_pipe_d     = {en_pipe_q[0], mac_issue};
        dp_en_acc     = en_pipe_q[1];
        dp_input_data = s_data;
        m_data        = dp_y;
        busy          = (state_q != ST_LOAD) || (ld_cnt_q != '0);
        dbg_state_o   = state_q;

        if (reset) begin
            s_ready       = 1'b0;
            dp_wr_en_x    = 1'b0;
            dp_addr_x     = '0;
            dp_addr_w     = '0;
            dp_clear_acc  = 1'b0;
            dp_en_acc     = 1'b0;
            m_valid       = 1'b0;
            m_last        = 1'b0;
            m_data        = '0;
            dp_f_sel      = '0;
            dp_input_data = '0;
            busy          = 1'b0;
            dbg_state_o   = '0;
        end
    end

endmodule

// File: tb/tb_mvm_seq_ctrl_relu.sv
// Bench for mvm_seq_ctrl_relu in two configurations (M=N=8,P=1 and
// M=N=4,P=2). Each configuration carries its own behavioural datapath
// (vector memory, weight ROM, saturating MACs, ReLU), a driver, and a
// scoreboard fed with dot products computed straight from the vector and
// the weight formula.
module tb_mvm_seq_ctrl_relu;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  bit done_flags [2];

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat8(input int v);
    return (v > 127) ? 127 : ((v < -128) ? -128 : v);
  endfunction

  // Weight of matrix element (row, col), range -7..7.
  function automatic int wfn(input int row, input int col);
    return ((row * 5 + col * 3 + 1) % 15) - 7;
  endfunction

  for (genvar k = 0; k < 2; k++) begin : g_cfg
    localparam int CM = (k == 0) ? 8 : 4;
    localparam int CN = (k == 0) ? 8 : 4;
    localparam int CP = (k == 0) ? 1 : 2;
    localparam int VS = $clog2(CN);
    localparam int MS = $clog2(CM * CN / CP);
    typedef int vec_t [CN];

    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [7:0]    s_data = '0;
    logic          m_valid;
    logic          m_ready = 1'b1;
    logic [7:0]    m_data;
    logic          m_last;
    logic          busy;
    logic [7:0]    dp_input_data;
    logic          dp_wr_en_x;
    logic [VS-1:0] dp_addr_x;
    logic [MS-1:0] dp_addr_w;
    logic          dp_clear_acc;
    logic          dp_en_acc;
    logic [CP-1:0] dp_f_sel;
    logic [7:0]    dp_y;
    logic [2:0]    dbg_state;

    int         ld_cnt = 0;
    bit         need_clr = 0;
    int         rdy_mode = 0;
    logic [7:0] exp_q[$];
    int         exp_row_q[$];

    mvm_seq_ctrl_relu #(.M(CM), .N(CN), .T(8), .P(CP)) dut (
      .clk(clk), .reset(rst),
      .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
      .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
      .busy(busy), .dp_input_data(dp_input_data), .dp_wr_en_x(dp_wr_en_x),
      .dp_addr_x(dp_addr_x), .dp_addr_w(dp_addr_w),
      .dp_clear_acc(dp_clear_acc), .dp_en_acc(dp_en_acc),
      .dp_f_sel(dp_f_sel), .dp_y(dp_y), .dbg_state_o(dbg_state)
    );

    // Datapath model: 1-cycle memory/ROM read, registered products,
    // saturating accumulators, ReLU on the selected lane.
    int xmem [CN];
    int x_rd;
    int w_rd [CP];
    int prod [CP];
    int acc  [CP];

    always @(posedge clk) begin
      if (dp_wr_en_x) xmem[int'(dp_addr_x) % CN] <= int'($signed(dp_input_data));
      x_rd <= xmem[int'(dp_addr_x) % CN];
      for (int l = 0; l < CP; l++) begin
        w_rd[l] <= wfn((int'(dp_addr_w) / CN) * CP + l, int'(dp_addr_w) % CN);
        prod[l] <= x_rd * w_rd[l];
        if (dp_clear_acc) acc[l] <= 0;
        else if (dp_en_acc) acc[l] <= sat8(acc[l] + prod[l]);
      end
    end

    always_comb begin
      int a;
      a = (int'(dp_f_sel) < CP) ? acc[int'(dp_f_sel)] : 0;
      dp_y = 8'((a < 0) ? 0 : a);
    end

    // Reference: row r of W times x, saturating at each step, then ReLU.
    function automatic int ref_y(input int r, input vec_t xv);
      int s = 0;
      for (int j = 0; j < CN; j++) s = sat8(s + wfn(r, j) * xv[j]);
      return (s < 0) ? 0 : s;
    endfunction

    task automatic rand_vec(output vec_t xv, input int lo, input int hi);
      for (int j = 0; j < CN; j++) xv[j] = int'($urandom_range(0, hi - lo)) + lo;
    endtask

    task automatic chk_all_zero(input string tag);
      chk({tag, "_s_ready"}, s_ready, 0);
      chk({tag, "_m_valid"}, m_valid, 0);
      chk({tag, "_wr_en"}, dp_wr_en_x, 0);
      chk({tag, "_en_acc"}, dp_en_acc, 0);
      chk({tag, "_clear"}, dp_clear_acc, 0);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_m_last"}, m_last, 0);
      chk({tag, "_m_data"}, m_data, 0);
      chk({tag, "_in_data"}, dp_input_data, 0);
      chk({tag, "_addr_x"}, dp_addr_x, 0);
      chk({tag, "_addr_w"}, dp_addr_w, 0);
      chk({tag, "_f_sel"}, dp_f_sel, 0);
      chk({tag, "_state"}, dbg_state, 0);
    endtask

    // Driver: streams one vector; mode 0 = continuous, 1 = toggling, 2 = random gaps.
    task automatic send_vec(input vec_t xv, input int mode);
      int i = 0;
      int t = 0;
      bit v, hs;
      while (i < CN) begin
        @(negedge clk);
        t++;
        if (t > 3000) begin
          chk($sformatf("c%0d_load_timeout", k), i, CN);
          s_valid = 1'b0;
          return;
        end
        case (mode)
          0:       v = 1'b1;
          1:       v = (t % 2 == 1);
          default: v = ($urandom_range(0, 2) != 0);
        endcase
        s_valid = v;
        s_data  = 8'(xv[i]);
        #1;
        hs = v && s_ready;
        chk($sformatf("c%0d_wr_en", k), dp_wr_en_x, hs);
        if (hs) begin
          chk($sformatf("c%0d_addr_x_ld", k), dp_addr_x, i);
          chk($sformatf("c%0d_in_data", k), dp_input_data, s_data);
        end
        @(posedge clk);
        if (hs) begin
          i++;
          ld_cnt = (i == CN) ? 0 : i;
        end
      end
      for (int r = 0; r < CM; r++) begin
        exp_row_q.push_back(r);
        exp_q.push_back(8'(ref_y(r, xv)));
      end
      need_clr = 1'b1;
      @(negedge clk);
      s_valid = 1'b0;
    endtask

    task automatic wait_idle();
      int t = 0;
      while (exp_row_q.size() != 0 && t < 5000) begin
        @(negedge clk);
        t++;
      end
      chk($sformatf("c%0d_drain_timeout", k), exp_row_q.size(), 0);
      repeat (2) @(negedge clk);
    endtask

    // Monitor/scoreboard: cycle-accurate expectations relative to each clear pulse.
    initial begin : mon
      int cyc = 0, clr_cyc = 0, grp = 0, out_i = 0, stall = 0, d;
      bit in_grp = 0, pv = 0;
      logic [7:0] pdata = '0;
      int pfsel = 0;
      string tg;
      tg = $sformatf("c%0d_", k);
      forever begin
        @(negedge clk);
        #2;
        cyc++;
        case (rdy_mode)
          0: m_ready = 1'b1;
          1: m_ready = ($urandom_range(0, 2) != 0);
          default: begin
            if (m_valid && stall < 5) begin
              m_ready = 1'b0;
              stall++;
            end else begin
              m_ready = 1'b1;
            end
          end
        endcase
        if (rst) begin
          in_grp = 0;
          pv = 0;
          need_clr = 0;
          continue;
        end
        if (need_clr) chk({tg, "clear_due"}, dp_clear_acc, 1);
        if (dp_clear_acc) begin
          chk({tg, "clear_in_group"}, in_grp, 0);
          chk({tg, "clear_has_work"}, exp_row_q.size() != 0, 1);
          in_grp = 1;
          clr_cyc = cyc;
          out_i = 0;
          stall = 0;
          grp = (exp_row_q.size() != 0) ? exp_row_q[0] / CP : 0;
        end
        need_clr = 0;
        d = cyc - clr_cyc;
        chk({tg, "en_acc"}, dp_en_acc, in_grp && d >= 3 && d <= CN + 2);
        chk({tg, "m_valid"}, m_valid, in_grp && d >= CN + 3);
        chk({tg, "s_ready"}, s_ready, exp_row_q.size() == 0);
        chk({tg, "busy"}, busy, ld_cnt != 0 || exp_row_q.size() != 0);
        if (in_grp && d >= 1 && d <= CN) begin
          chk({tg, "addr_x_mac"}, dp_addr_x, d - 1);
          chk({tg, "addr_w_mac"}, dp_addr_w, grp * CN + d - 1);
        end else if (in_grp) begin
          chk({tg, "addr_x_idle"}, dp_addr_x, 0);
          chk({tg, "addr_w_idle"}, dp_addr_w, 0);
        end
        if (pv) begin
          chk({tg, "hold_valid"}, m_valid, 1);
          chk({tg, "hold_data"}, m_data, pdata);
          chk({tg, "hold_f_sel"}, dp_f_sel, pfsel);
        end
        if (m_valid && exp_row_q.size() == 0) begin
          chk({tg, "unexpected_out"}, m_valid, 0);
        end else if (m_valid) begin
          chk({tg, "f_sel"}, dp_f_sel, exp_row_q[0] % CP);
          if (m_ready) begin
            chk({tg, "m_last"}, m_last, exp_row_q[0] == CM - 1);
            void'(exp_row_q.pop_front());
            chk({tg, "m_data"}, m_data, exp_q.pop_front());
            chk({tg, "relu_nonneg"}, m_data[7], 0);
            out_i++;
            if (out_i == CP) begin
              in_grp = 0;
              if (exp_row_q.size() != 0) need_clr = 1;
            end
          end
        end else begin
          chk({tg, "f_sel_idle"}, dp_f_sel, 0);
        end
        pv = m_valid && !m_ready;
        pdata = m_data;
        pfsel = int'(dp_f_sel);
      end
    end

    // Stimulus sequence for this configuration.
    initial begin : stim
      vec_t xv;
      int t;
      string tg;
      tg = $sformatf("c%0d_", k);
      // Reset with inputs active: every output must read zero.
      repeat (2) @(negedge clk);
      s_valid = 1'b1;
      s_data  = 8'h77;
      #1;
      chk_all_zero({tg, "rst"});
      s_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk({tg, "post_rst_ready"}, s_ready, 1);
      chk({tg, "post_rst_busy"}, busy, 0);

      // Ramp vector, continuous stream, m_ready held high.
      for (int j = 0; j < CN; j++) xv[j] = j + 1;
      rdy_mode = 0;
      send_vec(xv, 0);
      wait_idle();

      // Random vectors with random input gaps and random backpressure.
      rdy_mode = 1;
      for (int n = 0; n < 3; n++) begin
        rand_vec(xv, -4, 4);
        send_vec(xv, 2);
      end
      wait_idle();

      // Toggling s_valid.
      rdy_mode = 0;
      rand_vec(xv, -5, 5);
      send_vec(xv, 1);
      wait_idle();

      // Five stalled cycles at the start of every output group.
      rdy_mode = 2;
      rand_vec(xv, -6, 6);
      send_vec(xv, 0);
      wait_idle();

      // Saturation: all +127, then all -128.
      rdy_mode = 1;
      for (int j = 0; j < CN; j++) xv[j] = 127;
      send_vec(xv, 0);
      for (int j = 0; j < CN; j++) xv[j] = -128;
      send_vec(xv, 2);
      wait_idle();

      // Reset in the middle of MAC at j=3.
      rdy_mode = 0;
      rand_vec(xv, -4, 4);
      send_vec(xv, 0);
      #1;
      t = 0;
      while (!dp_clear_acc && t < 50) begin
        @(negedge clk);
        #1;
        t++;
      end
      chk({tg, "clear_seen"}, dp_clear_acc, 1);
      repeat (4) @(negedge clk);
      rst = 1'b1;
      s_data = 8'h5A;
      #1;
      chk_all_zero({tg, "midrst"});
      @(posedge clk);
      exp_q.delete();
      exp_row_q.delete();
      ld_cnt = 0;
      need_clr = 0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk({tg, "midrst_ready"}, s_ready, 1);
      chk({tg, "midrst_busy"}, busy, 0);
      chk({tg, "midrst_en"}, dp_en_acc, 0);
      chk({tg, "midrst_state"}, dbg_state, 0);

      // Fresh vectors after the abort, full data range.
      rdy_mode = 1;
      for (int n = 0; n < 2; n++) begin
        rand_vec(xv, -128, 127);
        send_vec(xv, 2);
      end
      wait_idle();
      done_flags[k] = 1'b1;
    end
  end

  initial begin : top
    int t = 0;
    while (!(done_flags[0] && done_flags[1]) && t < 60000) begin
      @(negedge clk);
      t++;
    end
    if (!(done_flags[0] && done_flags[1])) begin
      n_cmp++;
      n_fail++;
      $display("FAIL global_timeout: got not done expected done after %0d cycles", t);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
